// File: rtl/fp_accumulator_if.sv
// Stream and adder bus bundle for fp_accumulator.
// Ports: in_* operand stream, add_* adder link, out_* result stream.
interface fp_accumulator_if #(
    parameter int COUNT_W = 16
) ();
    // Operand stream (fetch -> accumulator)
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_data;
    logic               in_last;

    // Adder link (accumulator <-> external float32 adder)
    logic [31:0]        add_a;
    logic [31:0]        add_b;
    logic [31:0]        add_sum;

    // Result stream (accumulator -> consumer)
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_data;
    logic [COUNT_W-1:0] out_count;
    logic               out_ovf;

    // Accumulator side
    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  add_sum,
        input  out_ready,
        output in_ready,
        output add_a,
        output add_b,
        output out_valid,
        output out_data,
        output out_count,
        output out_ovf
    );

    // Environment side: operand source, adder and result sink
    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output add_sum,
        output out_ready,
        input  in_ready,
        input  add_a,
        input  add_b,
        input  out_valid,
        input  out_data,
        input  out_count,
        input  out_ovf
    );
endinterface

// File: rtl/fp_accumulator.sv
// Float32 stream reducer around an external adder: sums one stream per result.
// Ports: clk, rst_n (async low), clear (sync abort), bus (fp_accumulator_if.slave).
module fp_accumulator #(
    parameter int ADDER_LAT = 0,
    parameter int COUNT_W   = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    fp_accumulator_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRST,
        S_ACCUM,
        S_WAIT,
        S_OUT
    } state_e;

    localparam logic [2:0] LAT = 3'(ADDER_LAT);

    state_e             state_q, state_d;
    logic [31:0]        acc_q, acc_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic               last_q, last_d;
    logic [2:0]         wcnt_q, wcnt_d;

    logic               in_fire;
    logic               out_fire;
    logic               sum_inf;
    logic               in_inf;
    logic [COUNT_W-1:0] cnt_inc;

    assign bus.in_ready  = (state_q == S_FIRST) || (state_q == S_ACCUM);
    assign bus.out_valid = (state_q == S_OUT);
    assign bus.out_data  = acc_q;
    assign bus.out_count = cnt_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.add_a     = a_q;
    assign bus.add_b     = b_q;

    assign in_fire  = bus.in_valid & bus.in_ready;
    assign out_fire = bus.out_valid & bus.out_ready;
    assign sum_inf  = (bus.add_sum[30:23] == 8'hFF);
    assign in_inf   = (bus.in_data[30:23] == 8'hFF);

    // Element count sticks at all-ones instead of wrapping.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + COUNT_W'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        a_d     = a_q;
        b_d     = b_q;
        last_d  = last_q;
        wcnt_d  = wcnt_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_FIRST;
            end
            S_FIRST: begin
                // First element bypasses the adder so -0.0 and
                // denormals come through bit-exact.
                if (in_fire) begin
                    acc_d   = bus.in_data;
                    cnt_d   = COUNT_W'(1);
                    ovf_d   = in_inf;
                    state_d = bus.in_last ? S_OUT : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (in_fire) begin
                    a_d     = acc_q;
                    b_d     = bus.in_data;
                    last_d  = bus.in_last;
                    wcnt_d  = LAT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // add_sum is only trusted once the wait count hits 0.
                if (wcnt_q == 3'd0) begin
                    acc_d   = bus.add_sum;
                    cnt_d   = cnt_inc;
                    ovf_d   = ovf_q | sum_inf;
                    state_d = last_q ? S_OUT : S_ACCUM;
                end else begin
                    wcnt_d = wcnt_q - 3'd1;
                end
            end
            S_OUT: begin
                if (out_fire) begin
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_FIRST;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over any transfer in the same cycle; the adder
        // operand registers keep their last values.
        if (clear) begin
            state_d = S_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            a_d     = a_q;
            b_d     = b_q;
            last_d  = last_q;
            wcnt_d  = wcnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            last_q  <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            a_q     <= a_d;
            b_q     <= b_d;
            last_q  <= last_d;
            wcnt_q  <= wcnt_d;
        end
    end

endmodule

// File: tb/tb_fp_accumulator.sv
// Directed bench for fp_accumulator: two instances (ADDER_LAT 0 and 3).
// The external adder is a lookup table of hand-computed float32 sums.
module tb_fp_accumulator;

    logic clk;
    logic rst_n;
    logic clear0;
    logic clear1;

    int errs;
    int chks;

    fp_accumulator_if #(.COUNT_W(16)) bus0 ();
    fp_accumulator_if #(.COUNT_W(2))  bus1 ();

    fp_accumulator #(
        .ADDER_LAT(0),
        .COUNT_W  (16)
    ) dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(clear0),
        .bus  (bus0.slave)
    );

    fp_accumulator #(
        .ADDER_LAT(3),
        .COUNT_W  (2)
    ) dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(clear1),
        .bus  (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] fadd(input logic [31:0] a,
                                         input logic [31:0] b);
        logic [63:0] k;
        k = {a, b};
        case (k)
            64'h3F800000_40000000: fadd = 32'h40400000;
            64'h40400000_40400000: fadd = 32'h40C00000;
            64'h7F000000_7F000000: fadd = 32'h7F800000;
            64'h00000000_00000000: fadd = 32'h00000000;
            default:               fadd = 32'hBAD0BAD0;
        endcase
    endfunction

    // Zero-latency adder for dut0.
    assign bus0.add_sum = fadd(bus0.add_a, bus0.add_b);

    // Three-stage adder for dut1: early capture sees a stale sum.
    logic [31:0] p1, p2, p3;
    always_ff @(posedge clk) begin
        p1 <= fadd(bus1.add_a, bus1.add_b);
        p2 <= p1;
        p3 <= p2;
    end
    assign bus1.add_sum = p3;

    task automatic push(input bit sel, input logic [31:0] d,
                        input logic l, output int stall);
        stall = 0;
        @(negedge clk);
        if (sel) begin
            bus1.in_valid = 1'b1;
            bus1.in_data  = d;
            bus1.in_last  = l;
        end else begin
            bus0.in_valid = 1'b1;
            bus0.in_data  = d;
            bus0.in_last  = l;
        end
        while (!(sel ? bus1.in_ready : bus0.in_ready) && stall < 50) begin
            @(negedge clk);
            stall++;
        end
        if (!(sel ? bus1.in_ready : bus0.in_ready))
            stall = -1;
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
    endtask

    task automatic get(input bit sel, output logic [31:0] d,
                       output logic [15:0] c, output logic o,
                       output int lat);
        lat = 0;
        @(negedge clk);
        while (!(sel ? bus1.out_valid : bus0.out_valid) && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!(sel ? bus1.out_valid : bus0.out_valid))
            lat = -1;
        d = sel ? bus1.out_data : bus0.out_data;
        c = sel ? 16'(bus1.out_count) : bus0.out_count;
        o = sel ? bus1.out_ovf : bus0.out_ovf;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        chks++;
        if (bus0.in_ready !== 1'b0 || bus1.in_ready !== 1'b0) begin
            errs++;
            $display("FAIL rst_in_ready got %b/%b exp 0/0",
                     bus0.in_ready, bus1.in_ready);
        end
        chks++;
        if (bus0.out_valid !== 1'b0) begin
            errs++;
            $display("FAIL rst_out_valid got %b exp 0", bus0.out_valid);
        end
        chks++;
        if (bus0.add_a !== 32'h0 || bus0.add_b !== 32'h0) begin
            errs++;
            $display("FAIL rst_add got %h/%h exp 0/0",
                     bus0.add_a, bus0.add_b);
        end
        chks++;
        if (bus0.out_data !== 32'h0 || bus0.out_count !== 16'h0
            || bus0.out_ovf !== 1'b0) begin
            errs++;
            $display("FAIL rst_out got %h/%h/%b exp 0/0/0",
                     bus0.out_data, bus0.out_count, bus0.out_ovf);
        end
        rst_n = 1'b1;
        #1;
        chks++;
        if (bus0.in_ready !== 1'b0) begin
            errs++;
            $display("FAIL rst_bubble got %b exp 0", bus0.in_ready);
        end
        @(negedge clk);
        chks++;
        if (bus0.in_ready !== 1'b1 || bus1.in_ready !== 1'b1) begin
            errs++;
            $display("FAIL rst_first got %b/%b exp 1/1",
                     bus0.in_ready, bus1.in_ready);
        end
    endtask

    task automatic test_stream(input bit sel);
        int s1, s2, s3, lat, lt;
        logic [31:0] d;
        logic [15:0] c;
        logic o;
        lt = sel ? 3 : 0;
        push(sel, 32'h3F800000, 1'b0, s1);
        push(sel, 32'h40000000, 1'b0, s2);
        push(sel, 32'h40400000, 1'b1, s3);
        get(sel, d, c, o, lat);
        chks++;
        if (s1 !== 0 || s2 !== 0) begin
            errs++;
            $display("FAIL stream%0d_stall12 got %0d/%0d exp 0/0",
                     lt, s1, s2);
        end
        chks++;
        if (s3 !== lt + 1) begin
            errs++;
            $display("FAIL stream%0d_stall3 got %0d exp %0d", lt, s3, lt + 1);
        end
        chks++;
        if (d !== 32'h40C00000) begin
            errs++;
            $display("FAIL stream%0d_data got %h exp 40c00000", lt, d);
        end
        chks++;
        if (c !== 16'd3 || o !== 1'b0) begin
            errs++;
            $display("FAIL stream%0d_cnt got %0d/%b exp 3/0", lt, c, o);
        end
        chks++;
        if (lat !== lt + 1) begin
            errs++;
            $display("FAIL stream%0d_lat got %0d exp %0d", lt, lat, lt + 1);
        end
    endtask

    task automatic test_single();
        int s, lat;
        logic [31:0] d;
        logic [15:0] c;
        logic o;
        logic [31:0] vec [3];
        vec[0] = 32'h3F800000;
        vec[1] = 32'h80000000;
        vec[2] = 32'h00000001;
        for (int i = 0; i < 3; i++) begin
            push(1'b0, vec[i], 1'b1, s);
            get(1'b0, d, c, o, lat);
            chks++;
            if (d !== vec[i] || c !== 16'd1 || o !== 1'b0 || lat !== 0) begin
                errs++;
                $display("FAIL single%0d got %h/%0d/%b/%0d exp %h/1/0/0",
                         i, d, c, o, lat, vec[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int s, lat;
        logic [31:0] d;
        logic [15:0] c;
        logic o;
        push(1'b0, 32'h7F000000, 1'b0, s);
        push(1'b0, 32'h7F000000, 1'b1, s);
        get(1'b0, d, c, o, lat);
        chks++;
        if (d !== 32'h7F800000 || o !== 1'b1 || c !== 16'd2) begin
            errs++;
            $display("FAIL ovf_sum got %h/%b/%0d exp 7f800000/1/2", d, o, c);
        end
        push(1'b0, 32'h7F800000, 1'b1, s);
        get(1'b0, d, c, o, lat);
        chks++;
        if (d !== 32'h7F800000 || o !== 1'b1 || c !== 16'd1) begin
            errs++;
            $display("FAIL ovf_first got %h/%b/%0d exp 7f800000/1/1", d, o, c);
        end
        push(1'b0, 32'h3F800000, 1'b1, s);
        get(1'b0, d, c, o, lat);
        chks++;
        if (o !== 1'b0 || c !== 16'd1) begin
            errs++;
            $display("FAIL ovf_cleared got %b/%0d exp 0/1", o, c);
        end
    endtask

    task automatic test_backpressure();
        int s, n, lat;
        logic [31:0] d;
        logic [15:0] c;
        logic o;
        bus0.out_ready = 1'b0;
        push(1'b0, 32'h3F800000, 1'b0, s);
        push(1'b0, 32'h40000000, 1'b1, s);
        n = 0;
        @(negedge clk);
        while (!bus0.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chks++;
        if (bus0.out_valid !== 1'b1) begin
            errs++;
            $display("FAIL bp_valid got %b exp 1", bus0.out_valid);
        end
        bus0.in_valid = 1'b1;
        bus0.in_data  = 32'h3F800000;
        bus0.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chks++;
            if (bus0.out_data !== 32'h40400000 || bus0.out_count !== 16'd2
                || bus0.out_ovf !== 1'b0 || bus0.in_ready !== 1'b0
                || bus0.out_valid !== 1'b1) begin
                errs++;
                $display("FAIL bp_hold%0d got %h/%0d/%b rdy=%b vld=%b exp 40400000/2/0 rdy=0 vld=1",
                         i, bus0.out_data, bus0.out_count, bus0.out_ovf,
                         bus0.in_ready, bus0.out_valid);
            end
            @(negedge clk);
        end
        bus0.out_ready = 1'b1;
        @(negedge clk);
        chks++;
        if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1) begin
            errs++;
            $display("FAIL bp_release got vld=%b rdy=%b exp 0/1",
                     bus0.out_valid, bus0.in_ready);
        end
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        get(1'b0, d, c, o, lat);
        chks++;
        if (d !== 32'h3F800000 || c !== 16'd1 || lat !== 0) begin
            errs++;
            $display("FAIL bp_next got %h/%0d/%0d exp 3f800000/1/0", d, c, lat);
        end
    endtask

    task automatic test_clear();
        int s, lat;
        logic [31:0] d;
        logic [15:0] c;
        logic o;
        push(1'b1, 32'h3F800000, 1'b0, s);
        push(1'b1, 32'h40000000, 1'b0, s);
        @(negedge clk);
        clear1 = 1'b1;
        @(posedge clk);
        #1;
        clear1 = 1'b0;
        chks++;
        if (bus1.in_ready !== 1'b0 || bus1.out_valid !== 1'b0) begin
            errs++;
            $display("FAIL clr_idle got rdy=%b vld=%b exp 0/0",
                     bus1.in_ready, bus1.out_valid);
        end
        chks++;
        if (bus1.add_a !== 32'h3F800000 || bus1.add_b !== 32'h40000000) begin
            errs++;
            $display("FAIL clr_hold got %h/%h exp 3f800000/40000000",
                     bus1.add_a, bus1.add_b);
        end
        push(1'b1, 32'h40000000, 1'b1, s);
        chks++;
        if (s !== 1) begin
            errs++;
            $display("FAIL clr_bubble got %0d exp 1", s);
        end
        get(1'b1, d, c, o, lat);
        chks++;
        if (d !== 32'h40000000 || c !== 16'd1 || o !== 1'b0) begin
            errs++;
            $display("FAIL clr_result got %h/%0d/%b exp 40000000/1/0", d, c, o);
        end
    endtask

    task automatic test_saturate();
        int s, lat;
        logic [31:0] d;
        logic [15:0] c;
        logic o;
        for (int i = 0; i < 5; i++)
            push(1'b1, 32'h0, (i == 4), s);
        get(1'b1, d, c, o, lat);
        chks++;
        if (c !== 16'd3) begin
            errs++;
            $display("FAIL sat_count got %0d exp 3", c);
        end
        chks++;
        if (d !== 32'h0 || o !== 1'b0) begin
            errs++;
            $display("FAIL sat_data got %h/%b exp 0/0", d, o);
        end
    endtask

    task automatic test_async_reset();
        int s;
        push(1'b1, 32'h3F800000, 1'b0, s);
        push(1'b1, 32'h40000000, 1'b0, s);
        #2;
        rst_n = 1'b0;
        #1;
        chks++;
        if (bus1.add_a !== 32'h0 || bus1.add_b !== 32'h0) begin
            errs++;
            $display("FAIL arst_add got %h/%h exp 0/0", bus1.add_a, bus1.add_b);
        end
        chks++;
        if (bus1.out_data !== 32'h0 || bus1.out_count !== 2'd0
            || bus1.out_ovf !== 1'b0) begin
            errs++;
            $display("FAIL arst_out got %h/%0d/%b exp 0/0/0",
                     bus1.out_data, bus1.out_count, bus1.out_ovf);
        end
        chks++;
        if (bus1.in_ready !== 1'b0 || bus1.out_valid !== 1'b0) begin
            errs++;
            $display("FAIL arst_hs got rdy=%b vld=%b exp 0/0",
                     bus1.in_ready, bus1.out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chks++;
        if (bus1.in_ready !== 1'b0) begin
            errs++;
            $display("FAIL arst_bubble got %b exp 0", bus1.in_ready);
        end
        @(negedge clk);
        chks++;
        if (bus1.in_ready !== 1'b1) begin
            errs++;
            $display("FAIL arst_first got %b exp 1", bus1.in_ready);
        end
    endtask

    initial begin
        errs = 0;
        chks = 0;
        rst_n  = 1'b0;
        clear0 = 1'b0;
        clear1 = 1'b0;
        bus0.in_valid  = 1'b0;
        bus0.in_data   = 32'h0;
        bus0.in_last   = 1'b0;
        bus0.out_ready = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.in_data   = 32'h0;
        bus1.in_last   = 1'b0;
        bus1.out_ready = 1'b1;

        test_reset();
        test_stream(1'b0);
        test_stream(1'b1);
        test_single();
        test_overflow();
        test_backpressure();
        test_clear();
        test_saturate();
        test_async_reset();

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
